lagarto_plic_target_arbiter: RTL and testbench

//  Per-target PLIC arbiter: a sequential scan over all sources (one source per cycle)

---
 rtl/lagarto_plic_pkg.sv | 18 +
 rtl/lagarto_plic_target_arbiter.sv | 157 +++++++++++++++
 tb/tb_lagarto_plic_target_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lagarto_plic_pkg.sv
// Shared PLIC types: priority/ID widths, "no interrupt" encodings and the target scan states.
package lagarto_plic_pkg;

  localparam int unsigned PRIORITY_WIDTH = 3;
  localparam int unsigned ID_WIDTH       = 5;

  typedef logic [PRIORITY_WIDTH-1:0] interrupt_priority_t;
  typedef logic [ID_WIDTH-1:0]       interrupt_id_t;

  localparam interrupt_priority_t NO_INTERRUPT_PRIORITY = '0;
  localparam interrupt_id_t       NO_INTERRUPT_ID       = '0;

  typedef enum logic {
    SCAN,
    PUBLISH
  } plic_scan_state_t;

endpackage

// File: rtl/lagarto_plic_target_arbiter.sv
// Per-target PLIC arbiter: one-source-per-cycle scan for the best pending+enabled source,
// threshold compare to drive eip_o, and the claim/complete pulse handshake.
module lagarto_plic_target_arbiter
  import lagarto_plic_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 31
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                [NUM_SOURCES:0]  pending_i,
  input  logic                [NUM_SOURCES:0]  enable_i,
  input  interrupt_priority_t [NUM_SOURCES:0]  priority_i,
  input  interrupt_priority_t                  threshold_i,
  input  logic                                 claim_req_i,
  output logic                                 claim_valid_o,
  output interrupt_id_t                        claim_id_o,
  output logic                [NUM_SOURCES:0]  claim_o,
  input  logic                                 complete_req_i,
  input  interrupt_id_t                        complete_id_i,
  output logic                [NUM_SOURCES:0]  complete_o,
  output logic                                 eip_o,
  output interrupt_priority_t                  max_priority_o,
  output interrupt_id_t                        max_id_o
);

  plic_scan_state_t    r_state, w_state_d;
  interrupt_id_t       r_idx, w_idx_d;
  interrupt_priority_t r_best_prio, w_best_prio_d;
  interrupt_id_t       r_best_id, w_best_id_d;
  logic                r_eip, w_eip_d;
  interrupt_priority_t r_max_prio, w_max_prio_d;
  interrupt_id_t       r_max_id, w_max_id_d;
  logic                r_claim_valid;
  interrupt_id_t       r_claim_id;
  logic [NUM_SOURCES:0] r_claim, w_claim_d;
  logic [NUM_SOURCES:0] r_complete, w_complete_d;

  interrupt_priority_t w_cur_prio;
  logic                w_cur_ok;
  logic                w_better;
  interrupt_id_t       w_claim_id;

  // ID 0 is reserved, so its input bits are intentionally left unused.
  logic w_unused;
  assign w_unused = ^{pending_i[0], enable_i[0], priority_i[0]};

  always_comb begin
    w_cur_prio = NO_INTERRUPT_PRIORITY;
    w_cur_ok   = 1'b0;
    for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
      if (r_idx == interrupt_id_t'(i)) begin
        w_cur_prio = priority_i[i];
        w_cur_ok   = pending_i[i] & enable_i[i] & (priority_i[i] != NO_INTERRUPT_PRIORITY);
      end
    end
  end

  // Equal priority with a later index wins, giving ties to the greater ID.
  assign w_better = w_cur_ok & ((w_cur_prio > r_best_prio) |
                                ((w_cur_prio == r_best_prio) & (r_idx > r_best_id)));

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_best_prio_d = r_best_prio;
    w_best_id_d   = r_best_id;
    w_eip_d       = r_eip;
    w_max_prio_d  = r_max_prio;
    w_max_id_d    = r_max_id;
    if (claim_req_i) begin
      // A claim retires the published winner and restarts the scan from scratch.
      w_state_d     = SCAN;
      w_idx_d       = interrupt_id_t'(1);
      w_best_prio_d = NO_INTERRUPT_PRIORITY;
      w_best_id_d   = NO_INTERRUPT_ID;
      w_eip_d       = 1'b0;
      w_max_prio_d  = NO_INTERRUPT_PRIORITY;
      w_max_id_d    = NO_INTERRUPT_ID;
    end else begin
      unique case (r_state)
        SCAN: begin
          if (w_better) begin
            w_best_prio_d = w_cur_prio;
            w_best_id_d   = r_idx;
          end
          if (r_idx == interrupt_id_t'(NUM_SOURCES)) begin
            w_state_d = PUBLISH;
          end else begin
            w_idx_d = r_idx + interrupt_id_t'(1);
          end
        end
        PUBLISH: begin
          w_max_prio_d  = r_best_prio;
          w_max_id_d    = r_best_id;
          w_eip_d       = (r_best_prio > threshold_i);
          w_best_prio_d = NO_INTERRUPT_PRIORITY;
          w_best_id_d   = NO_INTERRUPT_ID;
          w_idx_d       = interrupt_id_t'(1);
          w_state_d     = SCAN;
        end
        default: w_state_d = SCAN;
      endcase
    end
  end

  assign w_claim_id = r_eip ? r_max_id : NO_INTERRUPT_ID;

  always_comb begin
    w_claim_d    = '0;
    w_complete_d = '0;
    for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
      if (claim_req_i && (w_claim_id == interrupt_id_t'(i))) begin
        w_claim_d[i] = 1'b1;
      end
      if (complete_req_i && (complete_id_i == interrupt_id_t'(i)) && enable_i[i]) begin
        w_complete_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= SCAN;
      r_idx         <= interrupt_id_t'(1);
      r_best_prio   <= NO_INTERRUPT_PRIORITY;
      r_best_id     <= NO_INTERRUPT_ID;
      r_eip         <= 1'b0;
      r_max_prio    <= NO_INTERRUPT_PRIORITY;
      r_max_id      <= NO_INTERRUPT_ID;
      r_claim_valid <= 1'b0;
      r_claim_id    <= NO_INTERRUPT_ID;
      r_claim       <= '0;
      r_complete    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_idx         <= w_idx_d;
      r_best_prio   <= w_best_prio_d;
      r_best_id     <= w_best_id_d;
      r_eip         <= w_eip_d;
      r_max_prio    <= w_max_prio_d;
      r_max_id      <= w_max_id_d;
      r_claim_valid <= claim_req_i;
      r_claim_id    <= claim_req_i ? w_claim_id : NO_INTERRUPT_ID;
      r_claim       <= w_claim_d;
      r_complete    <= w_complete_d;
    end
  end

  assign claim_valid_o  = r_claim_valid;
  assign claim_id_o     = r_claim_id;
  assign claim_o        = r_claim;
  assign complete_o     = r_complete;
  assign eip_o          = r_eip;
  assign max_priority_o = r_max_prio;
  assign max_id_o       = r_max_id;

endmodule

// File: tb/tb_lagarto_plic_target_arbiter.sv
// Bench for lagarto_plic_target_arbiter: directed scenarios plus random traffic, every cycle
// compared against a snapshot-and-argmax reference of the scan/claim/complete rules.
module tb_lagarto_plic_target_arbiter;
  import lagarto_plic_pkg::*;

  localparam int unsigned N = 7;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [N:0]                pending;
  logic [N:0]                enable;
  interrupt_priority_t [N:0] prio;
  interrupt_priority_t       thr;
  logic                      claim_req;
  logic                      complete_req;
  interrupt_id_t             complete_id;
  logic                      claim_valid;
  interrupt_id_t             claim_id;
  logic [N:0]                claim_vec;
  logic [N:0]                complete_vec;
  logic                      eip;
  interrupt_priority_t       max_prio;
  interrupt_id_t             max_id;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: per-source samples of the current scan window.
  int unsigned         m_phase;
  int                  m_snap [1:N];
  logic                m_eip;
  interrupt_id_t       m_max_id;
  interrupt_priority_t m_max_prio;
  logic                m_cv;
  interrupt_id_t       m_cid;
  logic [N:0]          m_claim;
  logic [N:0]          m_complete;

  interrupt_id_t bad_ids [3] = '{5'd0, 5'd9, 5'd4};

  always #5 clk = ~clk;

  lagarto_plic_target_arbiter #(
    .NUM_SOURCES(N)
  ) u_dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .pending_i     (pending),
    .enable_i      (enable),
    .priority_i    (prio),
    .threshold_i   (thr),
    .claim_req_i   (claim_req),
    .claim_valid_o (claim_valid),
    .claim_id_o    (claim_id),
    .claim_o       (claim_vec),
    .complete_req_i(complete_req),
    .complete_id_i (complete_id),
    .complete_o    (complete_vec),
    .eip_o         (eip),
    .max_priority_o(max_prio),
    .max_id_o      (max_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase    = 0;
    for (int i = 1; i <= N; i++) m_snap[i] = 0;
    m_eip      = 1'b0;
    m_max_id   = '0;
    m_max_prio = '0;
    m_cv       = 1'b0;
    m_cid      = '0;
    m_claim    = '0;
    m_complete = '0;
  endtask

  // Advance the reference by one clock using the inputs the DUT is about to sample.
  task automatic model_tick();
    int top;
    int win;
    m_cv  = claim_req;
    m_cid = (claim_req && m_eip) ? m_max_id : 5'd0;
    m_claim    = '0;
    m_complete = '0;
    for (int i = 1; i <= N; i++) begin
      if (claim_req && m_cid != 0 && int'(m_cid) == i) m_claim[i] = 1'b1;
      if (complete_req && int'(complete_id) == i && enable[i]) m_complete[i] = 1'b1;
    end
    if (claim_req) begin
      m_eip = 1'b0; m_max_id = '0; m_max_prio = '0; m_phase = 0;
      for (int i = 1; i <= N; i++) m_snap[i] = 0;
    end else if (m_phase < N) begin
      m_phase++;
      m_snap[m_phase] = (pending[m_phase] && enable[m_phase] && prio[m_phase] != 0) ?
                        int'(prio[m_phase]) : 0;
    end else begin
      top = 0;
      for (int i = 1; i <= N; i++) if (m_snap[i] > top) top = m_snap[i];
      win = 0;
      if (top > 0) for (int i = 1; i <= N; i++) if (m_snap[i] == top) win = i;
      m_max_prio = interrupt_priority_t'(top);
      m_max_id   = interrupt_id_t'(win);
      m_eip      = (top > int'(thr));
      m_phase    = 0;
      for (int i = 1; i <= N; i++) m_snap[i] = 0;
    end
  endtask

  task automatic compare_all();
    check("eip", 32'(eip), 32'(m_eip));
    check("max_id", 32'(max_id), 32'(m_max_id));
    check("max_prio", 32'(max_prio), 32'(m_max_prio));
    check("claim_valid", 32'(claim_valid), 32'(m_cv));
    check("claim_id", 32'(claim_id), 32'(m_cid));
    check("claim_o", 32'(claim_vec), 32'(m_claim));
    check("complete_o", 32'(complete_vec), 32'(m_complete));
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rstn = 1'b0; pending = '0; enable = '0; prio = '0; thr = '0;
    claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_eip", 32'(eip), 32'd0);
    check("init_max_id", 32'(max_id), 32'd0);
    compare_all();
    rstn = 1'b1;

    // Two candidates, higher priority wins.
    enable = 8'hFE; pending = 8'b0010_1000; prio[3] = 3'd2; prio[5] = 3'd5; thr = 3'd1;
    run(16);
    check("s2_max_id", 32'(max_id), 32'd5);
    check("s2_max_prio", 32'(max_prio), 32'd5);
    check("s2_eip", 32'(eip), 32'd1);

    // Asynchronous reset mid-scan, then first publish 8 cycles after release.
    run(3);
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_eip", 32'(eip), 32'd0);
    check("rst_max_id", 32'(max_id), 32'd0);
    check("rst_max_prio", 32'(max_prio), 32'd0);
    compare_all();
    #1 rstn = 1'b1;
    run(7);
    check("rst_pre_pub_eip", 32'(eip), 32'd0);
    run(1);
    check("rst_pub_eip", 32'(eip), 32'd1);
    check("rst_pub_id", 32'(max_id), 32'd5);

    // Tie toward greater ID, then fall back when it is disabled.
    prio = '0; prio[2] = 3'd4; prio[6] = 3'd4; pending = 8'b0100_0100; thr = 3'd0;
    run(16);
    check("tie_id", 32'(max_id), 32'd6);
    enable[6] = 1'b0;
    run(16);
    check("tie_dis_id", 32'(max_id), 32'd2);
    check("tie_dis_eip", 32'(eip), 32'd1);

    // Threshold equal blocks, threshold below passes.
    enable = 8'hFE; prio = '0; prio[5] = 3'd5; pending = 8'b0010_0000; thr = 3'd5;
    run(16);
    check("thr_eq_eip", 32'(eip), 32'd0);
    check("thr_eq_id", 32'(max_id), 32'd5);
    thr = 3'd4;
    run(16);
    check("thr_lt_eip", 32'(eip), 32'd1);

    // Claim handshake.
    pending = 8'b0010_1000; prio[3] = 3'd2; thr = 3'd1;
    run(16);
    claim_req = 1'b1;
    step();
    claim_req = 1'b0;
    check("clm_valid", 32'(claim_valid), 32'd1);
    check("clm_id", 32'(claim_id), 32'd5);
    check("clm_vec", 32'(claim_vec), 32'h20);
    check("clm_eip", 32'(eip), 32'd0);
    pending[5] = 1'b0;
    run(16);
    check("clm_next_id", 32'(max_id), 32'd3);
    thr = 3'd7;
    run(16);
    claim_req = 1'b1;
    step();
    claim_req = 1'b0;
    check("clm0_valid", 32'(claim_valid), 32'd1);
    check("clm0_id", 32'(claim_id), 32'd0);
    check("clm0_vec", 32'(claim_vec), 32'd0);
    thr = 3'd1;
    run(16);
    claim_req = 1'b1;
    step();
    check("b2b_first", 32'(claim_id), 32'd3);
    step();
    claim_req = 1'b0;
    check("b2b_second_valid", 32'(claim_valid), 32'd1);
    check("b2b_second_id", 32'(claim_id), 32'd0);

    // Completion filtering and simultaneous claim+complete.
    enable = 8'b1110_1110;
    run(16);
    complete_req = 1'b1; complete_id = 5'd5;
    step();
    complete_req = 1'b0;
    check("cmp5", 32'(complete_vec), 32'h20);
    step();
    check("cmp5_one_cycle", 32'(complete_vec), 32'd0);
    for (int k = 0; k < 3; k++) begin
      complete_req = 1'b1; complete_id = bad_ids[k];
      step();
      check("cmp_ignored", 32'(complete_vec), 32'd0);
    end
    claim_req = 1'b1; complete_req = 1'b1; complete_id = 5'd5;
    step();
    claim_req = 1'b0; complete_req = 1'b0;
    check("both_claim", 32'(claim_vec), 32'h08);
    check("both_complete", 32'(complete_vec), 32'h20);

    // Random traffic against the reference.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) pending = 8'($urandom);
      if ($urandom_range(0, 9) == 0) enable = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        for (int i = 0; i <= N; i++) prio[i] = interrupt_priority_t'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) thr = interrupt_priority_t'($urandom_range(0, 7));
      claim_req    = ($urandom_range(0, 11) == 0);
      complete_req = ($urandom_range(0, 5) == 0);
      complete_id  = interrupt_id_t'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0) begin
        rstn = 1'b0;
        #1 model_reset();
        compare_all();
        #1 rstn = 1'b1;
      end
      step();
    end
    claim_req = 1'b0; complete_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
